// File: rtl/instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline packing fields into a 32-bit word.
// Define ENC_RANGE_CHECK_EN to enable immediate range checking (o_err / o_err_cnt live).
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [15:0] o_word_cnt,
  output logic [7:0]  o_err_cnt
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_SH = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;
  localparam logic [2:0] FMT_U  = 3'd5;
  localparam logic [2:0] FMT_J  = 3'd6;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Handshake: a stage advances when it is empty or the stage after it advances;
  // a transfer happens on any cycle where valid and ready are both high, and the
  // producer keeps its payload stable while valid is high and ready is low.
  logic stage_a_adv;
  logic stage_b_adv;
  logic deliver;

  logic        a_valid;
  logic [2:0]  a_fmt;
  logic [6:0]  a_opcode;
  logic [4:0]  a_rd;
  logic [4:0]  a_rs1;
  logic [4:0]  a_rs2;
  logic [2:0]  a_funct3;
  logic [6:0]  a_funct7;
  logic [31:0] a_imm;

  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] packed_word;
  logic [15:0] word_cnt;

  assign stage_b_adv = !b_valid || i_ready;
  assign stage_a_adv = !a_valid || stage_b_adv;
  assign o_ready     = stage_a_adv;
  assign deliver     = b_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_valid  <= 1'b0;
      a_fmt    <= 3'd0;
      a_opcode <= 7'd0;
      a_rd     <= 5'd0;
      a_rs1    <= 5'd0;
      a_rs2    <= 5'd0;
      a_funct3 <= 3'd0;
      a_funct7 <= 7'd0;
      a_imm    <= 32'd0;
    end else if (stage_a_adv) begin
      a_valid <= i_valid;
      if (i_valid) begin
        a_fmt    <= i_fmt;
        a_opcode <= i_opcode;
        a_rd     <= i_rd;
        a_rs1    <= i_rs1;
        a_rs2    <= i_rs2;
        a_funct3 <= i_funct3;
        a_funct7 <= i_funct7;
        a_imm    <= i_imm;
      end
    end
  end

  // Out-of-range immediates are still packed, simply truncated to the field bits.
  always_comb begin
    packed_word = NOP_WORD;
    case (a_fmt)
      FMT_R:  packed_word = {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode};
      FMT_I:  packed_word = {a_imm[11:0], a_rs1, a_funct3, a_rd, a_opcode};
      FMT_SH: packed_word = {a_funct7, a_imm[4:0], a_rs1, a_funct3, a_rd, a_opcode};
      FMT_S:  packed_word = {a_imm[11:5], a_rs2, a_rs1, a_funct3, a_imm[4:0], a_opcode};
      FMT_B:  packed_word = {a_imm[12], a_imm[10:5], a_rs2, a_rs1, a_funct3,
                             a_imm[4:1], a_imm[11], a_opcode};
      FMT_U:  packed_word = {a_imm[31:12], a_rd, a_opcode};
      FMT_J:  packed_word = {a_imm[20], a_imm[10:1], a_imm[11], a_imm[19:12],
                             a_rd, a_opcode};
      default: packed_word = NOP_WORD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      b_valid <= 1'b0;
      b_instr <= 32'd0;
    end else if (stage_b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_instr <= packed_word;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt <= 16'd0;
    end else if (deliver) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  assign o_valid    = b_valid;
  assign o_instr    = b_instr;
  assign o_word_cnt = word_cnt;

`ifdef ENC_RANGE_CHECK_EN
  logic       range_err;
  logic       fits12;
  logic       fits13;
  logic       fits21;
  logic       a_err;
  logic       b_err;
  logic [7:0] err_cnt;

  // Sign-extension checks: the bits above the field must all equal its sign bit.
  assign fits12 = (i_imm[31:11] == 21'd0) || (i_imm[31:11] == {21{1'b1}});
  assign fits13 = (i_imm[31:12] == 20'd0) || (i_imm[31:12] == {20{1'b1}});
  assign fits21 = (i_imm[31:20] == 12'd0) || (i_imm[31:20] == {12{1'b1}});

  always_comb begin
    range_err = 1'b1;
    case (i_fmt)
      FMT_R:         range_err = 1'b0;
      FMT_I, FMT_S:  range_err = !fits12;
      FMT_SH:        range_err = (i_imm[31:5] != 27'd0);
      FMT_B:         range_err = i_imm[0] || !fits13;
      FMT_U:         range_err = (i_imm[11:0] != 12'd0);
      FMT_J:         range_err = i_imm[0] || !fits21;
      default:       range_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_err <= 1'b0;
    end else if (stage_a_adv && i_valid) begin
      a_err <= range_err;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      b_err <= 1'b0;
    end else if (stage_b_adv && a_valid) begin
      b_err <= a_err;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt <= 8'd0;
    end else if (deliver && b_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_err     = b_err;
  assign o_err_cnt = err_cnt;
`else
  assign o_err     = 1'b0;
  assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, back-pressure and reset sequences,
// and randomized traffic scored against a field-rule reference model.
module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [31:0] instr;
  logic        err;
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  instr_encoder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (in_valid),
    .o_ready    (out_ready),
    .i_fmt      (fmt),
    .i_opcode   (opcode),
    .i_rd       (rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct3   (funct3),
    .i_funct7   (funct7),
    .i_imm      (imm),
    .o_valid    (out_valid),
    .i_ready    (in_ready),
    .o_instr    (instr),
    .o_err      (err),
    .o_word_cnt (word_cnt),
    .o_err_cnt  (err_cnt)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  bundle_t     send_q[$];
  logic [15:0] exp_words = 16'd0;
  logic [7:0]  exp_errs = 8'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] held_instr = 32'd0;
  logic        held_err = 1'b0;
  logic        saw_stall = 1'b0;
  vec_t        tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // Reference model built from the field placement table and signed ranges.
  function automatic logic [32:0] model(input bundle_t b);
    logic [31:0] w;
    logic        e;
    longint      v;
    logic [31:0] op;
    logic [31:0] dst;
    logic [31:0] regs;
    v    = longint'($signed(b.imm));
    op   = 32'(b.opcode);
    dst  = 32'(b.rd) << 7;
    regs = (32'(b.rs1) << 15) | (32'(b.f3) << 12);
    w    = 32'h13;
    e    = 1'b1;
    case (b.fmt)
      3'd0: begin
        w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | regs | dst | op;
        e = 1'b0;
      end
      3'd1: begin
        w = ((b.imm & 32'hFFF) << 20) | regs | dst | op;
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (32'(b.f7) << 25) | ((b.imm & 32'h1F) << 20) | regs | dst | op;
        e = (v < 0) || (v > 31);
      end
      3'd3: begin
        w = (((b.imm >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | regs
            | ((b.imm & 32'h1F) << 7) | op;
        e = (v < -2048) || (v > 2047);
      end
      3'd4: begin
        w = (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25)
            | (32'(b.rs2) << 20) | regs | (((b.imm >> 1) & 32'hF) << 8)
            | (((b.imm >> 11) & 32'h1) << 7) | op;
        e = ((v % 2) != 0) || (v < -4096) || (v > 4094);
      end
      3'd5: begin
        w = (b.imm & 32'hFFFF_F000) | dst | op;
        e = (b.imm % 4096) != 0;
      end
      3'd6: begin
        w = (((b.imm >> 20) & 32'h1) << 31) | (((b.imm >> 1) & 32'h3FF) << 21)
            | (((b.imm >> 11) & 32'h1) << 20) | (((b.imm >> 12) & 32'hFF) << 12)
            | dst | op;
        e = ((v % 2) != 0) || (v < -1048576) || (v > 1048574);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e & RC, w};
  endfunction

  function automatic bundle_t mk(input int f, input int op, input int d, input int s1,
                                 input int s2, input int f3, input int f7,
                                 input logic [31:0] im);
    bundle_t b;
    b.fmt = 3'(f);  b.opcode = 7'(op); b.rd = 5'(d);   b.rs1 = 5'(s1);
    b.rs2 = 5'(s2); b.f3 = 3'(f3);     b.f7 = 7'(f7);  b.imm = im;
    return b;
  endfunction

  function automatic vec_t mkv(input bundle_t b, input logic [31:0] w, input logic e);
    vec_t v;
    v.b = b; v.instr = w; v.err = e;
    return v;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                    -4098, 1048574, 1048576, -1048576, -1048578, 31, 32, -1};
    b = mk($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
           $urandom_range(0, 127), 32'd0);
    case ($urandom_range(0, 5))
      0: b.imm = $urandom;
      1: b.imm = 32'($urandom_range(0, 40));
      2: b.imm = 32'(0 - $urandom_range(0, 40));
      3: b.imm = 32'(bnd[$urandom_range(0, 15)]);
      4: b.imm = $urandom & 32'hFFFF_F000;
      default: b.imm = 32'($urandom_range(0, 4000)) * 32'd2 - 32'd4000;
    endcase
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bundle_t b, input logic v);
    fmt = b.fmt; opcode = b.opcode; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm = b.imm; in_valid = v;
  endtask

  // Called just after a rising edge with an empty pipeline; checks two-edge latency.
  task automatic send_check(input vec_t t, input string name);
    in_ready = 1'b1;
    drive(t.b, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_instr"}, instr, t.instr);
    check({name, "_err"}, 32'(err), 32'(t.err & RC));
    @(posedge clk); #1;
  endtask

  // Feeds send_q with valid held until accepted; mode 0 ready always, 1 window stall, 2 random.
  task automatic run_stream(input int mode, input int budget);
    int cyc = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      case (mode)
        1:       in_ready = !(cyc >= 2 && cyc <= 4);
        2:       in_ready = ($urandom_range(0, 9) < 7);
        default: in_ready = 1'b1;
      endcase
      if (send_q.size() != 0) drive(send_q[0], 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && out_ready) void'(send_q.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    check("stream_drain", 32'(send_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bundle_t     cur;
    logic [32:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_words  = 16'd0;
      exp_errs   = 8'd0;
      prev_stall = 1'b0;
    end else begin
      check("o_ready", 32'(out_ready), 32'(!(exp_q.size() == 2 && !in_ready)));
      if (!out_ready) saw_stall = 1'b1;
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", instr, held_instr);
        check("hold_err", 32'(err), 32'(held_err));
      end
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", instr, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("word", instr, e[31:0]);
          check("word_err", 32'(err), 32'(e[32]));
          exp_words = exp_words + 16'd1;
          if (e[32] && exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
        end
      end
      prev_stall = out_valid && !in_ready;
      held_instr = instr;
      held_err   = err;
      if (in_valid && out_ready) begin
        cur = mk(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        exp_q.push_back(model(cur));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0), 1'b0);
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_ready", 32'(out_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0]  = mkv(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd5),          32'h0050_0093, 1'b0);
    tbl[1]  = mkv(mk(4, 7'h63, 0, 0, 0, 0, 0, -32'sd4),        32'hFE00_0EE3, 1'b0);
    tbl[2]  = mkv(mk(6, 7'h6F, 1, 0, 0, 0, 0, 32'd8),          32'h0080_00EF, 1'b0);
    tbl[3]  = mkv(mk(5, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5000),  32'h1234_52B7, 1'b0);
    tbl[4]  = mkv(mk(2, 7'h13, 1, 1, 0, 1, 0, 32'd3),          32'h0030_9093, 1'b0);
    tbl[5]  = mkv(mk(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048),       32'h8000_0093, 1'b1);
    tbl[6]  = mkv(mk(1, 7'h13, 1, 0, 0, 0, 0, -32'sd2048),     32'h8000_0093, 1'b0);
    tbl[7]  = mkv(mk(0, 7'h33, 3, 1, 2, 0, 7'h20, 32'd0),      32'h4020_81B3, 1'b0);
    tbl[8]  = mkv(mk(7, 7'h33, 3, 1, 2, 0, 7'h20, 32'd99),     32'h0000_0013, 1'b1);
    tbl[9]  = mkv(mk(3, 7'h23, 0, 1, 2, 2, 0, -32'sd4),        32'hFE20_AE23, 1'b0);
    tbl[10] = mkv(mk(4, 7'h63, 0, 0, 0, 0, 0, 32'd4094),       32'h7E00_0FE3, 1'b0);
    tbl[11] = mkv(mk(4, 7'h63, 0, 0, 0, 0, 0, 32'd4096),       32'h8000_0063, 1'b1);
    tbl[12] = mkv(mk(2, 7'h13, 1, 1, 0, 1, 0, 32'd32),         32'h0000_9093, 1'b1);
    tbl[13] = mkv(mk(5, 7'h37, 5, 0, 0, 0, 0, 32'h1234_5001),  32'h1234_52B7, 1'b1);
    tbl[14] = mkv(mk(6, 7'h6F, 1, 0, 0, 0, 0, 32'hFFF0_0000),  32'h8000_00EF, 1'b0);

    for (int i = 0; i < 15; i++) send_check(tbl[i], $sformatf("vec%0d", i));
    check("vec_word_cnt", 32'(word_cnt), 32'd15);
    check("vec_err_cnt", 32'(err_cnt), RC ? 32'd5 : 32'd0);

    // Back-pressure: five bundles with the sink stalled for three cycles.
    pulse_reset();
    saw_stall = 1'b0;
    for (int i = 0; i < 5; i++) send_q.push_back(mk(1, 7'h13, i + 1, i, 0, 0, 0, 32'(i * 7)));
    run_stream(1, 60);
    check("bp_stall_seen", 32'(saw_stall), 32'd1);
    check("bp_word_cnt", 32'(word_cnt), 32'd5);

    // Asynchronous reset with two words in flight.
    in_ready = 1'b0;
    drive(tbl[2].b, 1'b1);
    @(posedge clk); #1;
    drive(tbl[3].b, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("inflight_valid", 32'(out_valid), 32'd1);
    check("inflight_ready", 32'(out_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_word_cnt", 32'(word_cnt), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_ready", 32'(out_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    in_ready = 1'b1;
    @(posedge clk); #1;
    send_check(tbl[0], "post_rst");
    check("post_rst_word_cnt", 32'(word_cnt), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) send_q.push_back(rand_bundle());
    run_stream(2, 3000);
    check("rand_word_cnt", 32'(word_cnt), 32'(exp_words));
    check("rand_err_cnt", 32'(err_cnt), 32'(exp_errs));

    // Error counter saturation with a long run of reserved-format bundles.
    pulse_reset();
    for (int i = 0; i < 270; i++) send_q.push_back(mk(7, i, 0, 0, 0, 0, 0, 32'(i)));
    run_stream(0, 600);
    check("sat_word_cnt", 32'(word_cnt), 32'd270);
    check("sat_err_cnt", 32'(err_cnt), RC ? 32'hFF : 32'd0);
    check("sat_err_model", 32'(err_cnt), 32'(exp_errs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
